// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares one UART transmit line between two byte-stream requesters. Bytes are
// granted round-robin, one frame at a time; a requester may set its lock bit
// to keep the line for the next byte as well. Each granted byte goes out as
// 8N1 (start bit, 8 data bits LSB first, stop bit), CLKS_PER_BIT clocks per bit.
//
// Handshake: a byte moves from requester N to the arbiter in any cycle where
// reqN_valid and reqN_ready are both high at the rising edge of CLK. Ready is
// combinational, only ever high in IDLE, and never high for both requesters.
// A requester may drop valid before ready; that byte is then simply not sent.
//
// Ports:
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   req0_valid/data/lock   requester 0 byte offer and lock request
//   req0_ready             requester 0 byte accepted this cycle
//   req1_valid/data/lock   requester 1 byte offer and lock request
//   req1_ready             requester 1 byte accepted this cycle
//   busy                   frame in progress
//   grant_id               requester whose byte is on the line (valid while busy)
//   serial_txd             UART TX line, idle high
// ---------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    output logic       busy,
    output logic       grant_id,
    output logic       serial_txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_pri;
    logic            r_lock_hold;
    logic            r_grant_id;
    logic            r_busy;
    logic            r_txd;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic [CW-1:0]   r_baud_cnt;

    logic            w_ready0;
    logic            w_ready1;
    logic            w_xfer;
    logic            w_winner;
    logic            w_win_lock;
    logic [7:0]      w_win_data;
    logic            w_baud_wrap;

    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);
    assign w_xfer      = w_ready0 | w_ready1;
    assign w_winner    = w_ready1;
    assign w_win_lock  = w_winner ? req1_lock : req0_lock;
    assign w_win_data  = w_winner ? req1_data : req0_data;

    // Next-state and ready generation. Ready is also held low while RST_N is
    // asserted so nothing can look accepted during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        case (r_state)
            IDLE: begin
                if (RST_N) begin
                    if (r_lock_hold) begin
                        // Locked: only the holder may go, even if it is not valid.
                        w_ready0 = req0_valid & ~r_pri;
                        w_ready1 = req1_valid &  r_pri;
                    end else begin
                        w_ready0 = req0_valid & (~r_pri | ~req1_valid);
                        w_ready1 = req1_valid & ( r_pri | ~req0_valid);
                    end
                end
                if (w_ready0 | w_ready1) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_wrap) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_baud_wrap && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_baud_wrap) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath. serial_txd is registered, so the start bit appears the cycle
    // after the handshake and each bit value is loaded at the bit boundary.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pri       <= 1'b0;
            r_lock_hold <= 1'b0;
            r_grant_id  <= 1'b0;
            r_busy      <= 1'b0;
            r_txd       <= 1'b1;
            r_shift     <= 8'h00;
            r_bit_idx   <= 3'd0;
            r_baud_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 3'd0;
                    if (w_xfer) begin
                        r_shift     <= w_win_data;
                        r_grant_id  <= w_winner;
                        r_busy      <= 1'b1;
                        r_txd       <= 1'b0;
                        // A locked byte keeps priority on the winner; an
                        // unlocked byte hands priority to the other side.
                        r_pri       <= w_win_lock ? w_winner : ~w_winner;
                        r_lock_hold <= w_win_lock;
                    end
                end
                START: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_txd      <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_txd     <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CW'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign serial_txd = r_txd;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
`timescale 1ns/1ps
module tb_serial_tx_arbiter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    // ------------------------------------------------------------ clock/reset
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_lock = 1'b0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_lock = 1'b0;
    logic       req1_ready;
    logic       busy;
    logic       grant_id;
    logic       serial_txd;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    serial_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_lock(req1_lock), .req1_ready(req1_ready),
        .busy(busy), .grant_id(grant_id), .serial_txd(serial_txd)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ bookkeeping
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ driver state
    logic [8:0] q0[$];        // {lock, data} offers for requester 0
    logic [8:0] q1[$];
    bit         hold0 = 0, hold1 = 0;
    bit         rand_mode = 0;
    bit         drv_manual = 0;
    bit         man_pulse = 0;
    logic       man_v0 = 0, man_v1 = 0, man_l0 = 0, man_l1 = 0;
    logic [7:0] man_d0 = 0, man_d1 = 0;

    // ------------------------------------------------------------ reference model / scoreboard
    logic [8:0] exp_q[$];     // {winner, data} of granted bytes, in line order
    int         exp_cyc_q[$]; // handshake cycle of each granted byte
    bit         m_pri = 0;
    bit         m_lock = 0;
    int         m_free_at = 0; // first cycle in which a new grant is possible

    // line monitor output
    logic [7:0] line_log[$];
    logic       grant_log[$];
    int         start_log[$];
    bit         in_frame = 0;
    int         pos = 0;

    task automatic model_step();
        logic e0, e1, busy_exp;
        if (!RST_N) begin
            m_pri = 0; m_lock = 0; m_free_at = 0;
            exp_q.delete(); exp_cyc_q.delete();
            return;
        end
        busy_exp = (cyc < m_free_at);
        e0 = 1'b0; e1 = 1'b0;
        if (!busy_exp) begin
            if (m_lock) begin
                if (m_pri == 0) e0 = req0_valid; else e1 = req1_valid;
            end else if (req0_valid && req1_valid) begin
                if (m_pri == 0) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = req0_valid; e1 = req1_valid;
            end
        end
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        check("busy", 32'(busy), 32'(busy_exp));
        if (e0 || e1) begin
            exp_q.push_back({e1, e1 ? req1_data : req0_data});
            exp_cyc_q.push_back(cyc);
            m_free_at = cyc + FRAME + 1;
            if (e1 ? req1_lock : req0_lock) begin
                m_pri = e1; m_lock = 1;
            end else begin
                m_pri = !e1; m_lock = 0;
            end
        end
        // requesters react to the DUT's ready, as real requesters would
        if (!drv_manual && req0_ready && req0_valid && q0.size() > 0) begin
            void'(q0.pop_front()); hold0 = 0;
        end
        if (!drv_manual && req1_ready && req1_valid && q1.size() > 0) begin
            void'(q1.pop_front()); hold1 = 0;
        end
    endtask

    // ------------------------------------------------------------ driver
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (!RST_N) begin
                hold0 = 0; hold1 = 0; req0_valid = 0; req1_valid = 0;
            end else if (drv_manual) begin
                req0_valid = man_v0; req0_data = man_d0; req0_lock = man_l0;
                req1_valid = man_v1; req1_data = man_d1; req1_lock = man_l1;
            end else begin
                if (q0.size() == 0) begin
                    req0_valid = 0; hold0 = 0;
                end else if (hold0 && rand_mode && $urandom_range(0, 7) == 0) begin
                    req0_valid = 0; hold0 = 0;
                end else if (hold0 || !rand_mode || $urandom_range(0, 1) == 1) begin
                    req0_valid = 1; req0_data = q0[0][7:0]; req0_lock = q0[0][8]; hold0 = 1;
                end else begin
                    req0_valid = 0;
                end
                if (q1.size() == 0) begin
                    req1_valid = 0; hold1 = 0;
                end else if (hold1 && rand_mode && $urandom_range(0, 7) == 0) begin
                    req1_valid = 0; hold1 = 0;
                end else if (hold1 || !rand_mode || $urandom_range(0, 1) == 1) begin
                    req1_valid = 1; req1_data = q1[0][7:0]; req1_lock = q1[0][8]; hold1 = 1;
                end else begin
                    req1_valid = 0;
                end
            end
            #2;
            if (drv_manual && man_pulse) begin
                req0_valid = 0; req1_valid = 0;
            end
            #1;
            model_step();
        end
    end

    // ------------------------------------------------------------ line monitor
    function automatic logic frame_bit(input logic [7:0] d, input int p);
        logic [2:0] bi;
        if (p < CPB) return 1'b0;
        if (p < 9 * CPB) begin
            bi = 3'((p - CPB) / CPB);
            return d[bi];
        end
        return 1'b1;
    endfunction

    initial begin
        logic [8:0] cur;
        logic [7:0] got;
        logic [2:0] bi;
        int         hs;
        bit         have_exp;
        cur = '0; got = '0; have_exp = 0; hs = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                in_frame = 0;
            end else if (!in_frame && serial_txd == 1'b0) begin
                in_frame = 1; pos = 0; got = '0;
                check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                have_exp = (exp_q.size() != 0);
                if (have_exp) begin
                    cur = exp_q.pop_front();
                    hs = exp_cyc_q.pop_front();
                    check("frame_start_cycle", cyc, hs + 1);
                    check("grant_id", 32'(grant_id), 32'(cur[8]));
                end
                start_log.push_back(cyc);
            end
            if (RST_N && in_frame) begin
                if (have_exp) check("txd_bit", 32'(serial_txd), 32'(frame_bit(cur[7:0], pos)));
                if (pos >= CPB && pos < 9 * CPB && ((pos - CPB) % CPB) == CPB / 2) begin
                    bi = 3'((pos - CPB) / CPB);
                    got[bi] = serial_txd;
                end
                pos++;
                if (pos == FRAME) begin
                    in_frame = 0;
                    line_log.push_back(got);
                    grant_log.push_back(cur[8]);
                end
            end
        end
    end

    // ------------------------------------------------------------ test helpers
    typedef struct {
        logic v0;
        logic v1;
        logic e0;
        logic e1;
    } vec_t;
    vec_t tbl[8];

    task automatic apply_table(input int lo, input int hi);
        drv_manual = 1; man_pulse = 1;
        for (int i = lo; i <= hi; i++) begin
            @(posedge CLK);
            man_v0 = tbl[i].v0; man_v1 = tbl[i].v1;
            man_d0 = 8'($urandom_range(0, 255)); man_d1 = 8'($urandom_range(0, 255));
            man_l0 = 0; man_l1 = 0;
            @(negedge CLK);
            #2;
            check($sformatf("tbl%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].e0));
            check($sformatf("tbl%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].e1));
        end
        @(posedge CLK);
        man_v0 = 0; man_v1 = 0; man_pulse = 0;
        @(negedge CLK);
        #2;
        drv_manual = 0;
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic l);
        if (r == 0) q0.push_back({l, d}); else q1.push_back({l, d});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !in_frame && cyc >= m_free_at)
               && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < budget), 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic clear_logs();
        line_log.delete(); grant_log.delete(); start_log.delete();
    endtask

    task automatic check_log(input string name, input logic [31:0] eb, input logic [3:0] eg, input int n);
        check({name, "_count"}, line_log.size(), n);
        for (int i = 0; i < n && i < line_log.size(); i++) begin
            check({name, "_byte"}, 32'(line_log[i]), 32'(eb[8 * (n - 1 - i) +: 8]));
            check({name, "_grant"}, 32'(grant_log[i]), 32'(eg[n - 1 - i]));
        end
    endtask

    // ------------------------------------------------------------ main sequence
    logic [7:0] r0_list[$];
    logic [7:0] r1_list[$];

    initial begin
        int n;
        int k0, k1;
        logic [7:0] d;
        logic       l;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};   // pri = 0
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1};   // pri = 1
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};

        // reset state
        repeat (3) @(negedge CLK);
        #2;
        check("rst_txd", 32'(serial_txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        RST_N = 1'b1;

        // idle for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            #2;
            check("idle_txd", 32'(serial_txd), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready0", 32'(req0_ready), 32'd0);
            check("idle_ready1", 32'(req1_ready), 32'd0);
        end

        apply_table(0, 3);

        // single byte
        clear_logs();
        send(0, 8'hA5, 1'b0);
        wait_drain("single", 200);
        check_log("single", 32'h000000A5, 4'b0000, 1);

        apply_table(4, 7);

        clear_logs();
        send(1, 8'h5A, 1'b0);
        wait_drain("pri_flip", 200);
        check_log("pri_flip", 32'h0000005A, 4'b0001, 1);

        // contention
        clear_logs();
        @(posedge CLK);
        send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0);
        send(1, 8'h33, 1'b0); send(1, 8'h44, 1'b0);
        wait_drain("contention", 400);
        check_log("contention", 32'h11332244, 4'b0101, 4);
        for (int i = 0; i + 1 < start_log.size(); i++)
            check("contention_spacing", start_log[i + 1] - start_log[i], FRAME + 1);

        clear_logs();
        send(0, 8'hC3, 1'b0);
        wait_drain("pre_lock", 200);
        check_log("pre_lock", 32'h000000C3, 4'b0000, 1);

        // lock
        clear_logs();
        @(posedge CLK);
        send(1, 8'h55, 1'b1); send(1, 8'h66, 1'b1); send(1, 8'h77, 1'b0);
        send(0, 8'h99, 1'b0);
        wait_drain("lock", 400);
        check_log("lock", 32'h55667799, 4'b1110, 4);

        // lock stall: holder goes quiet, other requester must wait
        clear_logs();
        send(1, 8'hA1, 1'b1);
        wait_drain("stall_a", 200);
        send(0, 8'hB2, 1'b0);
        repeat (80) @(negedge CLK);
        check("stall_lines", line_log.size(), 1);
        check("stall_pending", q0.size(), 1);
        send(1, 8'hC4, 1'b0);
        wait_drain("stall_b", 400);
        check_log("stall", 32'h00A1C4B2, 4'b0110, 3);

        // valid withdrawal while busy
        clear_logs();
        send(0, 8'hE7, 1'b0);
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!busy && n < 100);
        check("withdraw_busy_timeout", 32'(busy), 32'd1);
        @(posedge CLK);
        drv_manual = 1; man_v0 = 1; man_d0 = 8'h81; man_l0 = 0;
        @(negedge CLK);
        #2;
        check("withdraw_ready0", 32'(req0_ready), 32'd0);
        @(posedge CLK);
        man_v0 = 0;
        @(negedge CLK);
        #2;
        drv_manual = 0;
        wait_drain("withdraw", 200);
        check_log("withdraw", 32'h000000E7, 4'b0000, 1);

        // reset during data bit 3
        clear_logs();
        send(0, 8'h37, 1'b0);
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!in_frame && n < 100);
        check("rst_mid_frame_timeout", 32'(in_frame), 32'd1);
        repeat (CPB + 3 * CPB + 1) @(negedge CLK);
        #2;
        check("pre_reset_txd_bit3", 32'(serial_txd), 32'd0);
        RST_N = 1'b0;
        #1;
        check("async_rst_txd", 32'(serial_txd), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_grant", 32'(grant_id), 32'd0);
        repeat (2) @(negedge CLK);
        #2;
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_txd", 32'(serial_txd), 32'd1);
        clear_logs();
        send(0, 8'h0F, 1'b0);
        wait_drain("post_rst", 200);
        check_log("post_rst", 32'h0000000F, 4'b0000, 1);

        // randomized traffic
        clear_logs();
        rand_mode = 1;
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom_range(0, 255)); l = ($urandom_range(0, 3) == 0) && (i != 24);
            r0_list.push_back(d); send(0, d, l);
            d = 8'($urandom_range(0, 255)); l = ($urandom_range(0, 3) == 0) && (i != 24);
            r1_list.push_back(d); send(1, d, l);
        end
        wait_drain("random", 12000);
        rand_mode = 0;
        k0 = 0; k1 = 0;
        for (int i = 0; i < line_log.size(); i++) begin
            if (grant_log[i] == 1'b0) begin
                if (k0 < r0_list.size()) check("rand_order0", 32'(line_log[i]), 32'(r0_list[k0]));
                k0++;
            end else begin
                if (k1 < r1_list.size()) check("rand_order1", 32'(line_log[i]), 32'(r1_list[k1]));
                k1++;
            end
        end
        check("rand_count0", k0, 25);
        check("rand_count1", k1, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
